// File: rtl/image_sharpen_stream.sv
`default_nettype none
// ============================================================================
//  Module      : image_sharpen_stream
//  Description : Streaming 3x3 Laplacian-style sharpen filter (4- or 8-
//                neighbour kernel) with zero-padded borders and optional
//                output clamping. Raster-order pixel stream in and out.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_sharpen_stream #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [PIX_W-1:0]          in_pixel,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic                      sat_en,
    output logic                      out_valid,
    output logic signed [PIX_W+4:0]   out_pixel,
    output logic                      out_eol,
    output logic                      frame_done
);

    localparam int c_OW    = PIX_W + 5;
    // Two full rows plus the two extra taps of the window trailing the newest pixel
    localparam int c_DEPTH = 2 * IMG_W + 2;
    localparam int c_TOTAL = IMG_W * IMG_H + IMG_W + 1;
    localparam int c_CW    = $clog2(c_TOTAL + 1);
    localparam int c_XW    = $clog2(IMG_W);
    localparam int c_YW    = $clog2(IMG_H);

    localparam logic [c_CW-1:0] c_FILL_LAST  = c_CW'(IMG_W);
    localparam logic [c_CW-1:0] c_RUN_LAST   = c_CW'(IMG_W * IMG_H - 1);
    localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'(c_TOTAL - 1);
    localparam logic [c_CW-1:0] c_EMIT_MIN   = c_CW'(IMG_W + 1);
    localparam logic [c_XW-1:0] c_XMAX       = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_YMAX       = c_YW'(IMG_H - 1);
    localparam logic signed [c_OW-1:0] c_PMAX = c_OW'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CW-1:0]         r_in_cnt;     // pixels (real or flush) pushed this frame
    logic [c_XW-1:0]         r_ccol;       // column of the next output centre
    logic [c_YW-1:0]         r_crow;       // row of the next output centre
    logic                    r_mode;
    logic                    r_sat;
    logic [PIX_W-1:0]        r_line [0:c_DEPTH-1];

    logic                    w_acc;
    logic                    w_adv;
    logic                    w_emit;
    logic [PIX_W-1:0]        w_new;
    logic                    w_up, w_dn, w_lf, w_rt;
    logic signed [c_OW-1:0]  w_c, w_n, w_s, w_e, w_w, w_ne, w_nw, w_se, w_sw;
    logic signed [c_OW-1:0]  w_cross, w_diag, w_raw, w_res;

    // Zero-extend a pixel into the signed datapath, or drop it if it lies outside the image
    function automatic logic signed [c_OW-1:0] tap(input logic [PIX_W-1:0] p, input logic en);
        return en ? $signed({5'b0, p}) : '0;
    endfunction

    assign in_ready = (r_state != S_FLUSH);
    assign w_acc    = in_valid && in_ready;
    // Flush cycles push a dummy pixel so the last row drains at one output per cycle
    assign w_adv    = w_acc || (r_state == S_FLUSH);
    assign w_emit   = w_adv && (r_in_cnt >= c_EMIT_MIN);
    assign w_new    = (r_state == S_FLUSH) ? '0 : in_pixel;

    // Border masks come from the centre position, so stale buffer data never leaks in
    assign w_up = (r_crow != '0);
    assign w_dn = (r_crow != c_YMAX);
    assign w_lf = (r_ccol != '0);
    assign w_rt = (r_ccol != c_XMAX);

    // Window taps relative to the incoming pixel j: r_line[i] holds pixel j-1-i
    assign w_c  = tap(r_line[IMG_W],       1'b1);
    assign w_n  = tap(r_line[2*IMG_W],     w_up);
    assign w_s  = tap(r_line[0],           w_dn);
    assign w_w  = tap(r_line[IMG_W+1],     w_lf);
    assign w_e  = tap(r_line[IMG_W-1],     w_rt);
    assign w_nw = tap(r_line[2*IMG_W+1],   w_up && w_lf);
    assign w_ne = tap(r_line[2*IMG_W-1],   w_up && w_rt);
    assign w_sw = tap(r_line[1],           w_dn && w_lf);
    assign w_se = tap(w_new,               w_dn && w_rt);

    // Kernel arithmetic and optional clamp to the unsigned pixel range
    always_comb begin
        w_cross = w_n + w_s + w_e + w_w;
        w_diag  = w_ne + w_nw + w_se + w_sw;
        if (r_mode) begin
            w_raw = (w_c <<< 3) + w_c - w_cross - w_diag;
        end else begin
            w_raw = (w_c <<< 2) + w_c - w_cross;
        end
        w_res = w_raw;
        if (r_sat) begin
            if (w_raw < 0) begin
                w_res = '0;
            end else if (w_raw > c_PMAX) begin
                w_res = c_PMAX;
            end
        end
    end

    // Two-row delay line; contents are never cleared because borders are masked by counters
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_line[0] <= w_new;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: fill until the first window is complete, run, then drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_state_nxt = S_FILL;
            S_FILL:  if (w_acc && r_in_cnt == c_FILL_LAST) w_state_nxt = S_RUN;
            S_RUN:   if (w_acc && r_in_cnt == c_RUN_LAST) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_in_cnt == c_FLUSH_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame counters, per-frame mode capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt   <= '0;
            r_ccol     <= '0;
            r_crow     <= '0;
            r_mode     <= 1'b0;
            r_sat      <= 1'b0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (w_adv) begin
                if (r_state == S_FLUSH && r_in_cnt == c_FLUSH_LAST) begin
                    r_in_cnt <= '0;
                end else begin
                    r_in_cnt <= r_in_cnt + c_CW'(1);
                end
            end
            if (r_state == S_IDLE && w_acc) begin
                r_mode <= mode;
                r_sat  <= sat_en;
            end
            if (w_emit) begin
                if (r_ccol == c_XMAX) begin
                    r_ccol <= '0;
                    r_crow <= (r_crow == c_YMAX) ? '0 : r_crow + c_YW'(1);
                end else begin
                    r_ccol <= r_ccol + c_XW'(1);
                end
            end
            out_valid  <= w_emit;
            out_eol    <= w_emit && (r_ccol == c_XMAX);
            frame_done <= w_emit && (r_ccol == c_XMAX) && (r_crow == c_YMAX);
            if (w_emit) begin
                out_pixel <= w_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_sharpen_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_sharpen_stream
//  Description : Directed self-checking bench for image_sharpen_stream
//                on a 4x4 image with 8-bit pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sharpen_stream;

    localparam int W = 4;
    localparam int H = 4;
    localparam int PW = 8;

    typedef int frame_t [16];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_pixel = '0;
    logic          mode = 1'b0;
    logic          sat_en = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [PW+4:0] out_pixel;
    logic          out_eol;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    int out_v[$];
    bit out_e[$];
    bit out_f[$];
    int ready_low = 0;

    frame_t flat100   = '{default: 100};
    frame_t impulse   = '{0,0,0,0, 0,255,0,0, 0,0,0,0, 0,0,0,0};
    frame_t exp_m0    = '{300,200,200,300, 200,100,100,200, 200,100,100,200, 300,200,200,300};
    frame_t exp_m1    = '{600,400,400,600, 400,100,100,400, 400,100,100,400, 600,400,400,600};
    frame_t exp_imp   = '{-255,-255,-255,0, -255,2295,-255,0, -255,-255,-255,0, 0,0,0,0};
    frame_t exp_imp_s = '{0,0,0,0, 0,255,0,0, 0,0,0,0, 0,0,0,0};

    image_sharpen_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .mode       (mode),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .out_eol    (out_eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Output monitor: record every output and count cycles with in_ready low
    always @(negedge clk) begin
        if (out_valid) begin
            out_v.push_back(int'($signed(out_pixel)));
            out_e.push_back(out_eol);
            out_f.push_back(frame_done);
        end
        if (rst_n && !in_ready) ready_low++;
    end

    // Present pixels first..last at falling edges; optionally idle every other cycle
    task automatic drive_px(input frame_t px, input int first, input int last, input bit gaps);
        int i = first;
        int guard = 0;
        bit skip = 1'b0;
        while (i <= last && guard < 200) begin
            @(negedge clk);
            guard++;
            if (in_ready && !(gaps && skip)) begin
                in_valid = 1'b1;
                in_pixel = px[i][PW-1:0];
                i++;
            end else begin
                in_valid = 1'b0;
            end
            skip = ~skip;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int g = 0;
        while (out_v.size() < target && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++;
        if (out_pixel !== '0) begin n_fail++; $display("FAIL reset_out_pixel got=%0d exp=0", out_pixel); end
        n_checks++;
        if (out_eol !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got eol=%0b fd=%0b exp=0 0", out_eol, frame_done);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat_mode0();
        int base = out_v.size();
        int lo = ready_low;
        mode = 1'b0; sat_en = 1'b0;
        drive_px(flat100, 0, 15, 1'b0);
        wait_out(base + 16);
        n_checks++;
        if (out_v.size() - base !== 16) begin n_fail++; $display("FAIL flat0_count got=%0d exp=16", out_v.size() - base); end
        for (int i = 0; i < 16 && base + i < out_v.size(); i++) begin
            n_checks++;
            if (out_v[base+i] !== exp_m0[i] || out_e[base+i] !== (i % W == W-1) || out_f[base+i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL flat0[%0d] got val=%0d eol=%0b fd=%0b exp val=%0d eol=%0b fd=%0b", i,
                         out_v[base+i], out_e[base+i], out_f[base+i], exp_m0[i], (i % W == W-1), (i == 15));
            end
        end
        n_checks++;
        if (ready_low - lo !== W + 1) begin n_fail++; $display("FAIL flat0_ready_low got=%0d exp=%0d", ready_low - lo, W + 1); end
    endtask

    task automatic test_flat_mode1();
        int base = out_v.size();
        mode = 1'b1; sat_en = 1'b0;
        drive_px(flat100, 0, 15, 1'b0);
        wait_out(base + 16);
        n_checks++;
        if (out_v.size() - base !== 16) begin n_fail++; $display("FAIL flat1_count got=%0d exp=16", out_v.size() - base); end
        for (int i = 0; i < 16 && base + i < out_v.size(); i++) begin
            n_checks++;
            if (out_v[base+i] !== exp_m1[i]) begin
                n_fail++; $display("FAIL flat1[%0d] got=%0d exp=%0d", i, out_v[base+i], exp_m1[i]);
            end
        end
    endtask

    task automatic test_impulse();
        int base = out_v.size();
        mode = 1'b1; sat_en = 1'b0;
        drive_px(impulse, 0, 15, 1'b0);
        sat_en = 1'b1;
        drive_px(impulse, 0, 15, 1'b0);
        wait_out(base + 32);
        n_checks++;
        if (out_v.size() - base !== 32) begin n_fail++; $display("FAIL impulse_count got=%0d exp=32", out_v.size() - base); end
        for (int i = 0; i < 32 && base + i < out_v.size(); i++) begin
            int e;
            e = (i < 16) ? exp_imp[i] : exp_imp_s[i-16];
            n_checks++;
            if (out_v[base+i] !== e) begin
                n_fail++; $display("FAIL impulse_sat%0d[%0d] got=%0d exp=%0d", i / 16, i % 16, out_v[base+i], e);
            end
        end
    endtask

    task automatic test_gapped();
        int base = out_v.size();
        int lo = ready_low;
        mode = 1'b1; sat_en = 1'b0;
        drive_px(impulse, 0, 15, 1'b1);
        wait_out(base + 16);
        n_checks++;
        if (out_v.size() - base !== 16) begin n_fail++; $display("FAIL gapped_count got=%0d exp=16", out_v.size() - base); end
        for (int i = 0; i < 16 && base + i < out_v.size(); i++) begin
            n_checks++;
            if (out_v[base+i] !== exp_imp[i] || out_f[base+i] !== (i == 15)) begin
                n_fail++; $display("FAIL gapped[%0d] got val=%0d fd=%0b exp val=%0d fd=%0b", i,
                                   out_v[base+i], out_f[base+i], exp_imp[i], (i == 15));
            end
        end
        n_checks++;
        if (ready_low - lo !== W + 1) begin n_fail++; $display("FAIL gapped_ready_low got=%0d exp=%0d", ready_low - lo, W + 1); end
    endtask

    task automatic test_reset_mid_frame();
        int base = out_v.size();
        int fd_seen = 0;
        mode = 1'b0; sat_en = 1'b0;
        drive_px(flat100, 0, 6, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_v.size() - base !== 2) begin n_fail++; $display("FAIL midrst_pre_count got=%0d exp=2", out_v.size() - base); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pixel !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got valid=%0b pix=%0d exp 0 0", out_valid, out_pixel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = base; i < out_v.size(); i++) fd_seen += int'(out_f[i]);
        n_checks++;
        if (fd_seen !== 0) begin n_fail++; $display("FAIL midrst_frame_done got=%0d exp=0", fd_seen); end
        base = out_v.size();
        drive_px(flat100, 0, 15, 1'b0);
        wait_out(base + 16);
        n_checks++;
        if (out_v.size() - base !== 16) begin n_fail++; $display("FAIL midrst_count got=%0d exp=16", out_v.size() - base); end
        for (int i = 0; i < 16 && base + i < out_v.size(); i++) begin
            n_checks++;
            if (out_v[base+i] !== exp_m0[i] || out_f[base+i] !== (i == 15)) begin
                n_fail++; $display("FAIL midrst[%0d] got val=%0d fd=%0b exp val=%0d fd=%0b", i,
                                   out_v[base+i], out_f[base+i], exp_m0[i], (i == 15));
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = out_v.size();
        int lo = ready_low;
        sat_en = 1'b0;
        mode = 1'b1;
        drive_px(flat100, 0, 7, 1'b0);
        mode = 1'b0;
        drive_px(flat100, 8, 15, 1'b0);
        drive_px(flat100, 0, 15, 1'b0);
        wait_out(base + 32);
        n_checks++;
        if (out_v.size() - base !== 32) begin n_fail++; $display("FAIL b2b_count got=%0d exp=32", out_v.size() - base); end
        for (int i = 0; i < 32 && base + i < out_v.size(); i++) begin
            int e;
            e = (i < 16) ? exp_m1[i] : exp_m0[i-16];
            n_checks++;
            if (out_v[base+i] !== e || out_f[base+i] !== (i % 16 == 15)) begin
                n_fail++; $display("FAIL b2b_frame%0d[%0d] got val=%0d fd=%0b exp val=%0d fd=%0b", i / 16 + 1, i % 16,
                                   out_v[base+i], out_f[base+i], e, (i % 16 == 15));
            end
        end
        n_checks++;
        if (ready_low - lo !== 2 * (W + 1)) begin n_fail++; $display("FAIL b2b_ready_low got=%0d exp=%0d", ready_low - lo, 2 * (W + 1)); end
    endtask

    initial begin
        test_reset();
        test_flat_mode0();
        test_flat_mode1();
        test_impulse();
        test_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
